// File: rtl/pixel_loader_pkg.sv
// Shared types and constants for the SPI pixel loader.
package pixel_loader_pkg;

  localparam int PIXEL_BYTES = 72;

  typedef enum logic [1:0] {
    IDLE,
    RECV,
    DONE
  } loader_state_t;

endpackage

// File: rtl/spi_input_sync.sv
// Synchronizes the asynchronous SPI pins into clk and produces registered
// sclk-rise and ss_n fall/rise pulses (one cycle each).
module spi_input_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic n_rst,
  input  logic sclk_i,
  input  logic ss_n_i,
  input  logic mosi_i,
  output logic mosi_o,
  output logic ss_n_o,
  output logic sclk_rise_o,
  output logic ss_fall_o,
  output logic ss_rise_o
);

  logic [SYNC_STAGES-1:0] sclk_sync_q, ss_sync_q, mosi_sync_q;
  logic sclk_prev_q, ss_prev_q;
  logic sclk_rise_q, ss_fall_q, ss_rise_q;

  // ss_n chain resets high so leaving reset never looks like a frame start.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      sclk_sync_q <= '0;
      ss_sync_q   <= '1;
      mosi_sync_q <= '0;
      sclk_prev_q <= 1'b0;
      ss_prev_q   <= 1'b1;
      sclk_rise_q <= 1'b0;
      ss_fall_q   <= 1'b0;
      ss_rise_q   <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk_i};
      ss_sync_q   <= {ss_sync_q[SYNC_STAGES-2:0], ss_n_i};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi_i};
      sclk_prev_q <= sclk_sync_q[SYNC_STAGES-1];
      ss_prev_q   <= ss_sync_q[SYNC_STAGES-1];
      sclk_rise_q <= sclk_sync_q[SYNC_STAGES-1] & ~sclk_prev_q;
      ss_fall_q   <= ~ss_sync_q[SYNC_STAGES-1] & ss_prev_q;
      ss_rise_q   <= ss_sync_q[SYNC_STAGES-1] & ~ss_prev_q;
    end
  end

  assign mosi_o      = mosi_sync_q[SYNC_STAGES-1];
  assign ss_n_o      = ss_sync_q[SYNC_STAGES-1];
  assign sclk_rise_o = sclk_rise_q;
  assign ss_fall_o   = ss_fall_q;
  assign ss_rise_o   = ss_rise_q;

endmodule

// File: rtl/spi_pixel_loader.sv
// Mode-0 SPI frame receiver feeding the pixel store one byte per write/shift pulse.
// Define PIXEL_LOADER_ERR_EN to build the sticky frame_error/overrun flags.
module spi_pixel_loader
  import pixel_loader_pkg::*;
#(
  parameter int NUM_BYTES   = PIXEL_BYTES,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       sclk,
  input  logic       ss_n,
  input  logic       mosi,
  input  logic       net_busy,
  output logic [7:0] spi_in,
  output logic       shift_SPI,
  output logic       write_en,
  output logic       frame_done,
  output logic       frame_error,
  output logic       overrun,
  output logic       busy
);

  localparam int CW = $clog2(NUM_BYTES + 1);

  logic mosi_s, ss_n_s, sclk_rise, ss_fall, ss_rise;

  spi_input_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk        (clk),
    .n_rst      (n_rst),
    .sclk_i     (sclk),
    .ss_n_i     (ss_n),
    .mosi_i     (mosi),
    .mosi_o     (mosi_s),
    .ss_n_o     (ss_n_s),
    .sclk_rise_o(sclk_rise),
    .ss_fall_o  (ss_fall),
    .ss_rise_o  (ss_rise)
  );

  loader_state_t state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [CW-1:0] byte_cnt_q, byte_cnt_d;
  logic [6:0]    shreg_q, shreg_d;
  logic [7:0]    pend_dat_q, pend_dat_d, spi_in_q, spi_in_d;
  logic          pend_vld_q, pend_vld_d;
  logic          wr, frame_full, frame_start, trunc, drop;
  logic [7:0]    byte_new;

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    byte_cnt_d  = byte_cnt_q;
    shreg_d     = shreg_q;
    pend_dat_d  = pend_dat_q;
    pend_vld_d  = pend_vld_q;
    spi_in_d    = spi_in_q;
    wr          = 1'b0;
    frame_done  = 1'b0;
    frame_start = 1'b0;
    trunc       = 1'b0;
    drop        = 1'b0;
    frame_full  = (byte_cnt_q == CW'(NUM_BYTES));
    byte_new    = {shreg_q, mosi_s};

    case (state_q)
      IDLE: begin
        if (ss_fall) begin
          state_d     = RECV;
          bit_cnt_d   = '0;
          byte_cnt_d  = '0;
          pend_vld_d  = 1'b0;
          frame_start = 1'b1;
        end
      end
      RECV: begin
        if (ss_rise && !frame_full) begin
          // Early deselect: the pending byte is abandoned, never written.
          state_d    = IDLE;
          bit_cnt_d  = '0;
          byte_cnt_d = '0;
          pend_vld_d = 1'b0;
          trunc      = 1'b1;
        end else if (frame_full && !pend_vld_q) begin
          state_d    = DONE;
          frame_done = 1'b1;
        end else begin
          wr = pend_vld_q && !net_busy;
          if (wr) begin
            pend_vld_d = 1'b0;
            byte_cnt_d = byte_cnt_q + 1'b1;
            spi_in_d   = pend_dat_q;
          end
          if (sclk_rise) begin
            shreg_d   = byte_new[6:0];
            bit_cnt_d = bit_cnt_q + 3'd1;
            // A byte completing as the last slot fills is surplus to the frame.
            if (bit_cnt_q == 3'd7 && byte_cnt_d != CW'(NUM_BYTES)) begin
              if (pend_vld_q && !wr) begin
                drop = 1'b1;
              end else begin
                pend_vld_d = 1'b1;
                pend_dat_d = byte_new;
              end
            end
          end
        end
      end
      DONE: begin
        if (ss_n_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q    <= IDLE;
      bit_cnt_q  <= '0;
      byte_cnt_q <= '0;
      shreg_q    <= '0;
      pend_dat_q <= '0;
      pend_vld_q <= 1'b0;
      spi_in_q   <= '0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      shreg_q    <= shreg_d;
      pend_dat_q <= pend_dat_d;
      pend_vld_q <= pend_vld_d;
      spi_in_q   <= spi_in_d;
    end
  end

  assign spi_in    = wr ? pend_dat_q : spi_in_q;
  assign shift_SPI = wr;
  assign write_en  = wr;
  assign busy      = (state_q == RECV);

`ifdef PIXEL_LOADER_ERR_EN
  logic err_q, ovr_q;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      err_q <= 1'b0;
      ovr_q <= 1'b0;
    end else if (frame_start) begin
      err_q <= 1'b0;
      ovr_q <= 1'b0;
    end else begin
      if (trunc) err_q <= 1'b1;
      if (drop)  ovr_q <= 1'b1;
    end
  end

  assign frame_error = err_q;
  assign overrun     = ovr_q;
`else
  logic unused_err;
  assign unused_err  = ^{frame_start, trunc, drop};
  assign frame_error = 1'b0;
  assign overrun     = 1'b0;
`endif

endmodule

// File: tb/tb_spi_pixel_loader.sv
// Bench for spi_pixel_loader: frame table plus reset-abort sequence, with a queue-based model of written bytes.
module tb_spi_pixel_loader;

  localparam int NB = 72;
  localparam int SS = 2;
  localparam int H  = 4;

  logic       clk = 1'b0, n_rst = 1'b0, sclk = 1'b0, ss_n = 1'b1, mosi = 1'b0, net_busy = 1'b0;
  logic [7:0] spi_in;
  logic       shift_SPI, write_en, frame_done, frame_error, overrun, busy;

  spi_pixel_loader #(.NUM_BYTES(NB), .SYNC_STAGES(SS)) dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .sclk       (sclk),
    .ss_n       (ss_n),
    .mosi       (mosi),
    .net_busy   (net_busy),
    .spi_in     (spi_in),
    .shift_SPI  (shift_SPI),
    .write_en   (write_en),
    .frame_done (frame_done),
    .frame_error(frame_error),
    .overrun    (overrun),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  logic [7:0] wq[$];
  int         wcyc[$];
  int         dcyc[$];

  always @(negedge clk) begin
    if (n_rst) begin
      chk("write_en_eq_shift", int'(write_en), int'(shift_SPI));
      if (shift_SPI) begin
        chk("no_write_while_net_busy", int'(net_busy), 0);
        wq.push_back(spi_in);
        wcyc.push_back(cyc);
      end
      if (frame_done) dcyc.push_back(cyc);
    end
  end

  int bcnt = 0, rel_cyc = -1, rise_cyc0 = -1;

  task automatic tick();
    @(posedge clk);
    #1;
    if (bcnt > 0) begin
      bcnt--;
      if (bcnt == 0) begin
        net_busy = 1'b0;
        rel_cyc  = cyc;
      end
    end
  endtask

  // busy_byte >= 0: fixed busy window from bit 4 of that byte; -2: random short windows.
  task automatic send_bits(input logic [7:0] b, input int nbits, input int bidx,
                           input int busy_byte, input int busy_len);
    for (int i = 0; i < nbits; i++) begin
      mosi = b[7-i];
      if (i == 4 && bidx == busy_byte) begin
        net_busy = 1'b1;
        bcnt     = busy_len;
      end else if (i == 4 && busy_byte == -2 && bcnt == 0 && $urandom_range(0, 3) == 0) begin
        net_busy = 1'b1;
        bcnt     = int'($urandom_range(1, 20));
      end
      repeat (H) tick();
      sclk = 1'b1;
      if (i == 7 && bidx == 0) rise_cyc0 = cyc;
      repeat (H) tick();
      sclk = 1'b0;
    end
  endtask

  typedef struct {
    int nbytes;
    int busy_byte;
    int busy_len;
    int drop_idx;
    bit rnd;
    int exp_pulses;
    bit exp_done;
  } vec_t;

  vec_t tbl[8];

  task automatic run_frame(input vec_t v, input string tag);
    logic [7:0] fr[$];
    logic [7:0] exp_q[$];
    bit exp_err, exp_ovr;
    wq.delete(); wcyc.delete(); dcyc.delete();
    rel_cyc = -1;
    for (int i = 0; i < v.nbytes; i++) fr.push_back(v.rnd ? 8'($urandom) : 8'(i));
    // Model: bytes accepted in send order, minus the dropped one, capped at one frame.
    for (int i = 0; i < v.nbytes; i++)
      if (i != v.drop_idx && exp_q.size() < NB) exp_q.push_back(fr[i]);
`ifdef PIXEL_LOADER_ERR_EN
    exp_err = (exp_q.size() < NB);
    exp_ovr = (v.drop_idx >= 0);
`else
    exp_err = 1'b0;
    exp_ovr = 1'b0;
`endif
    ss_n = 1'b0;
    repeat (SS + 3) tick();
    chk({tag, "_busy_recv"}, int'(busy), 1);
    for (int i = 0; i < v.nbytes; i++) send_bits(fr[i], 8, i, v.busy_byte, v.busy_len);
    repeat (H) tick();
    ss_n = 1'b1;
    repeat (SS + 4) tick();
    chk({tag, "_pulses"}, wq.size(), v.exp_pulses);
    for (int i = 0; i < exp_q.size() && i < wq.size(); i++)
      chk($sformatf("%s_data%0d", tag, i), int'(wq[i]), int'(exp_q[i]));
    chk({tag, "_done_count"}, dcyc.size(), int'(v.exp_done));
    if (v.exp_done && dcyc.size() > 0 && wcyc.size() > 0)
      chk({tag, "_done_latency"}, dcyc[0], wcyc[wcyc.size()-1] + 1);
    if (wcyc.size() > 0)
      chk({tag, "_write_latency"}, wcyc[0], rise_cyc0 + SS + 2);
    if (v.busy_byte >= 0 && wcyc.size() > 5)
      chk({tag, "_byte5_at_release"}, wcyc[5], rel_cyc);
    if (wq.size() > 0)
      chk({tag, "_spi_in_hold"}, int'(spi_in), int'(wq[wq.size()-1]));
    chk({tag, "_busy_idle"}, int'(busy), 0);
    chk({tag, "_frame_error"}, int'(frame_error), int'(exp_err));
    chk({tag, "_overrun"}, int'(overrun), int'(exp_ovr));
    repeat (10) tick();
  endtask

  initial begin
    //          nbytes busy_b len  drop rnd pulses done
    tbl[0] = '{72,    -1,    0,   -1,  0,  72,    1};
    tbl[1] = '{72,     5,    42,  -1,  0,  72,    1};
    tbl[2] = '{72,     5,    110,  6,  0,  71,    0};
    tbl[3] = '{10,    -1,    0,   -1,  0,  10,    0};
    tbl[4] = '{72,    -1,    0,   -1,  0,  72,    1};
    tbl[5] = '{73,    -1,    0,   -1,  0,  72,    1};
    tbl[6] = '{72,    -2,    0,   -1,  1,  72,    1};
    tbl[7] = '{72,    -2,    0,   -1,  1,  72,    1};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_spi_in", int'(spi_in), 0);
    chk("rst_shift", int'(shift_SPI), 0);
    chk("rst_write_en", int'(write_en), 0);
    chk("rst_frame_done", int'(frame_done), 0);
    chk("rst_frame_error", int'(frame_error), 0);
    chk("rst_overrun", int'(overrun), 0);
    chk("rst_busy", int'(busy), 0);
    n_rst = 1'b1;
    repeat (5) tick();

    for (int k = 0; k < 8; k++) run_frame(tbl[k], $sformatf("vec%0d", k));

    // Reset in the middle of byte 20.
    wq.delete(); wcyc.delete(); dcyc.delete();
    ss_n = 1'b0;
    repeat (SS + 3) tick();
    for (int i = 0; i < 20; i++) send_bits(8'(8'h80 + i), 8, i, -1, 0);
    send_bits(8'hA5, 3, 20, -1, 0);
    n_rst = 1'b0;
    #1;
    chk("midrst_spi_in", int'(spi_in), 0);
    chk("midrst_shift", int'(shift_SPI), 0);
    chk("midrst_write_en", int'(write_en), 0);
    chk("midrst_frame_done", int'(frame_done), 0);
    chk("midrst_frame_error", int'(frame_error), 0);
    chk("midrst_overrun", int'(overrun), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_writes_before", wq.size(), 20);
    if (wq.size() == 20) chk("midrst_last_byte", int'(wq[19]), 8'h93);
    ss_n = 1'b1;
    repeat (3) tick();
    n_rst = 1'b1;
    repeat (3) tick();
    run_frame(tbl[0], "after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/spi_pixel_loader.md
# spi_pixel_loader

Upstream feeder for the 72-byte pixel shift register: receives one image frame over a mode-0 SPI link, deserializes it MSB-first into bytes, and issues a one-cycle combined write/shift pulse per byte into the pixel store. It synchronizes the asynchronous SPI pins into the system clock domain and tracks the frame byte count. It defers writes while the network side is shifting the store, and flags truncated frames and overruns.

## Interface
- `NUM_BYTES`, 72: bytes per frame, equal to the pixel store depth.
- `SYNC_STAGES`, 2: flip-flop stages on each asynchronous SPI input.
- `clk`  in  1  system clock.
- `n_rst`  in  1  asynchronous, active-low reset.
- `sclk`  in  1  SPI clock from the master, asynchronous to `clk`.
- `ss_n`  in  1  SPI slave select, active low, asynchronous.
- `mosi`  in  1  SPI data, asynchronous.
- `net_busy`  in  1  high while the network is driving `shift_network` into the pixel store.
- `spi_in`  out  8  byte presented to the pixel store.
- `shift_SPI`  out  1  one-cycle shift strobe to the pixel store.
- `write_en`  out  1  one-cycle write select; always equal to `shift_SPI`.
- `frame_done`  out  1  one-cycle pulse after the `NUM_BYTES`th write.
- `frame_error`  out  1  sticky; set when a frame is truncated.
- `overrun`  out  1  sticky; set when a byte is dropped.
- `busy`  out  1  high in RECV.

## Operation
- Inputs pass through `SYNC_STAGES` flops. The synchronized `sclk` rising edge, detected by a one-flop edge detector, samples the synchronized `mosi` into an 8-bit shift register, MSB first.
- State machine:
  - IDLE: entered on reset. Waits for a synchronized `ss_n` falling edge.
  - IDLE → RECV on that edge: clears the bit count, the byte count, `frame_error` and `overrun`.
  - RECV: every 8th sampled bit completes a byte.
  - RECV → DONE when the byte count reaches `NUM_BYTES` and no write is pending. `frame_done` pulses on entry.
  - DONE → IDLE when `ss_n` goes high.
  - RECV → IDLE when `ss_n` goes high early, i.e. byte count below `NUM_BYTES`. This sets `frame_error` (see Configuration). Counters and the pending byte are discarded.
- On byte completion the byte is loaded into a one-entry pending register.
  - The first cycle the register is full and `net_busy` is low, the block drives `spi_in` = byte and `shift_SPI` = `write_en` = 1 for exactly one cycle.
  - It then clears the pending register and increments the byte count.
- If a byte completes while one is still pending, the new byte is dropped and `overrun` is set. The pending byte is kept and the byte count is not advanced.
- In DONE, further sampled bits are ignored; no writes occur.
- `spi_in` holds its last driven value between pulses.
- Byte count width is `$clog2(NUM_BYTES+1)`. The bit counter is 3 bits and wraps 7 → 0 on byte completion.

## Timing
- Every output is 0 in reset.
- Input requirement: `sclk` high and low phases each at least `SYNC_STAGES`+1 `clk` periods. `ss_n` setup before the first `sclk` edge is at least `SYNC_STAGES`+1 periods.
- Latency, with `net_busy` low:
  - Sampling: the raw `sclk` edge of the 8th bit reaches the sample point after `SYNC_STAGES`+1 cycles.
  - Pending load: the pending register loads on that cycle.
  - Write: the write pulse appears the next cycle.
- `frame_done` asserts the cycle after the `NUM_BYTES`th write pulse.
- `net_busy` is sampled each cycle. A write never coincides with a cycle where `net_busy` is 1.
- Reset mid-frame returns the block to IDLE immediately and discards all partial data.
- A write pending when reset or early `ss_n` deassertion occurs is never issued.

## Configuration
- `PIXEL_LOADER_ERR_EN` defined: `frame_error` and `overrun` behave as above.
- Undefined: both outputs are tied 0 and their registers are not built. Truncation and drop behaviour are otherwise identical.

## Structure
- Package `pixel_loader_pkg`:
  - state enum `loader_state_t` {IDLE, RECV, DONE};
  - localparam `PIXEL_BYTES` = 72, used as the `NUM_BYTES` default.
- Sub-module `spi_input_sync`: per-bit synchronizer chain for `sclk`, `ss_n` and `mosi`, plus registered `sclk` rise and `ss_n` fall/rise pulses.

## Test plan
- Full frame, bytes 0x00..0x47, `net_busy` = 0 → 72 write pulses with `spi_in` = 0x00..0x47 in order; `frame_done` asserts once, 1 cycle after the 72nd pulse; `frame_error` = 0.
- `net_busy` = 1 from before byte 5 completes until 10 cycles later → the byte-5 pulse occurs the first cycle `net_busy` = 0 with the correct value; no overrun.
- `net_busy` held high across completion of bytes 5 and 6 → byte 5 written after release, byte 6 absent, `overrun` = 1, total pulses 71, no `frame_done`.
- `ss_n` raised after 10 bytes → IDLE, `frame_error` = 1. The next full frame clears the flag and yields 72 correct writes.
- 73rd byte clocked before `ss_n` rises → ignored; exactly 72 pulses.
- `n_rst` asserted after 3 bits of byte 20 → all outputs 0 the same cycle. After release, a new frame loads cleanly from byte 0.
